// File: rtl/csa_accum_seq.sv
// rtl/csa_accum_seq.sv - sequential carry-save reduction of Booth partial products into a (sum, carry) pair
module csa_accum_seq #(
    parameter int WIDTH  = 32,
    parameter int NUM_PP = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [WIDTH-1:0] pp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_vec,
    output logic [WIDTH-1:0] carry_vec,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_PP - 1);

    state_t           state, state_nx;
    logic [7:0]       count, count_nx;
    logic [WIDTH-1:0] sum_nx, carry_nx;
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-2:0] row_k;
    logic             pp_xfer, out_xfer;

    // The majority MSB would carry out of the word, so it is never formed.
    assign row_s = sum_vec ^ carry_vec ^ pp_data;
    assign row_k = (sum_vec[WIDTH-2:0] & carry_vec[WIDTH-2:0])
                 | (sum_vec[WIDTH-2:0] & pp_data[WIDTH-2:0])
                 | (carry_vec[WIDTH-2:0] & pp_data[WIDTH-2:0]);

    assign pp_xfer  = pp_valid & pp_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        sum_nx    = sum_vec;
        carry_nx  = carry_vec;
        pp_ready  = (state != DONE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pp_xfer) begin
                    sum_nx   = pp_data;
                    carry_nx = '0;
                    count_nx = 8'd1;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (pp_xfer) begin
                    sum_nx   = row_s;
                    carry_nx = {row_k, 1'b0};
                    count_nx = count + 8'd1;
                    if (count == LAST_IDX) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // Result registers are left intact after hand-off.
                if (out_xfer) begin
                    count_nx = 8'd0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            sum_vec   <= '0;
            carry_vec <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            sum_vec   <= sum_nx;
            carry_vec <= carry_nx;
        end
    end

endmodule
